// File: rtl/hazard_scoreboard_if.sv
// Issue-side hazard interface: ID/EX operand descriptors in, stall and long-unit status out.
interface hazard_scoreboard_if #(
  parameter int unsigned PERF_W = 16
);
  logic              ID_valid;
  logic [4:0]        ID_rs1;
  logic [4:0]        ID_rs2;
  logic              ID_use_rs1;
  logic              ID_use_rs2;
  logic [4:0]        ID_rd;
  logic              ID_RegWrite;
  logic              ID_is_long;
  logic              EX_MemRead;
  logic [4:0]        EX_rd;
  logic              flush;
  logic              stall;
  logic              long_busy;
  logic [4:0]        long_rd;
  logic              long_wb;
  logic [PERF_W-1:0] stall_count;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_RegWrite,
           ID_is_long, EX_MemRead, EX_rd, flush,
    input  stall, long_busy, long_rd, long_wb, stall_count
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_RegWrite,
           ID_is_long, EX_MemRead, EX_rd, flush,
    output stall, long_busy, long_rd, long_wb, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: load-use detection against EX plus a single in-flight long-latency
// (MUL/DIV) op tracked with a per-register pending bit. Drives the pipeline freeze/bubble.
module hazard_scoreboard #(
  parameter int unsigned LONG_LAT = 8,
  parameter int unsigned PERF_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  hazard_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic [4:0]        r_long_rd;
  logic [31:0]       r_pending;
  logic [PERF_W-1:0] r_stall_count;

  logic w_busy;
  logic w_load_use;
  logic w_raw_long;
  logic w_waw_long;
  logic w_struct;
  logic w_stall;
  logic w_issue;
  logic w_load_rd;
  logic w_set_pend;
  logic w_clr_pend;

  assign w_busy = (r_state != IDLE);

  // Hazard detection; x0 never matches because EX_rd!=0 is required and pending[0] stays clear.
  always_comb begin
    w_load_use = bus.EX_MemRead && (bus.EX_rd != '0) &&
                 ((bus.ID_use_rs1 && (bus.ID_rs1 == bus.EX_rd)) ||
                  (bus.ID_use_rs2 && (bus.ID_rs2 == bus.EX_rd)));
    w_raw_long = (bus.ID_use_rs1 && r_pending[bus.ID_rs1]) ||
                 (bus.ID_use_rs2 && r_pending[bus.ID_rs2]);
    w_waw_long = bus.ID_RegWrite && r_pending[bus.ID_rd];
    w_struct   = bus.ID_is_long && w_busy;
    w_stall    = rstn && bus.ID_valid && !bus.flush &&
                 (w_load_use || w_raw_long || w_waw_long || w_struct);
    w_issue    = bus.ID_valid && !bus.flush && !w_stall;
  end

  // Long-unit next state: counter reload on issue, countdown while busy, release after DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_rd   = 1'b0;
    w_set_pend  = 1'b0;
    w_clr_pend  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue && bus.ID_is_long) begin
          w_cnt_nxt   = 8'(LONG_LAT);
          w_state_nxt = BUSY;
          w_load_rd   = 1'b1;
          w_set_pend  = bus.ID_RegWrite && (bus.ID_rd != '0);
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd2) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
        w_clr_pend  = 1'b1;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Long-unit state, countdown and destination register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_long_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load_rd) begin
        r_long_rd <= bus.ID_rd;
      end
    end
  end

  // Pending-write scoreboard; set and clear never coincide since DONE blocks a new long issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
    end else begin
      if (w_clr_pend) begin
        r_pending[r_long_rd] <= 1'b0;
      end
      if (w_set_pend) begin
        r_pending[bus.ID_rd] <= 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.long_busy   = w_busy;
  assign bus.long_rd     = r_long_rd;
  assign bus.long_wb     = (r_state == DONE);
  assign bus.stall_count = r_stall_count;

endmodule
